// File: rtl/digit_select_top_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_select_top_pkg
//  Description : Shared types and constants for the largest-K-digit
//                subsequence engine: data width, digit type and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_select_top_pkg;

  localparam int DATA_WIDTH = 32;

  // One decimal digit, 0..9
  typedef logic [3:0] digit_t;

  // FSM encoding for the line controller
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_DRAIN   = 2'd1;
  localparam state_t S_DONE    = 2'd2;
  localparam state_t S_WAIT_NL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/digit_select_top_monotonic_stack.sv
`default_nettype none
// ============================================================================
//  Module      : monotonic_stack
//  Description : Non-increasing digit stack of depth max_cap. In one cycle it
//                pops every entry smaller than the incoming digit (but never
//                below floor_sp) and pushes the digit, or drops the digit when
//                the stack cannot take it.
//  Ports       : clock, reset (async, active-low)
//                push_en/digit/floor_sp - offered digit and minimum keep depth
//                clear                  - synchronous wipe for the next line
//                rd_idx/rd_digit        - drain read port (0 beyond sp)
//                full/empty             - stack occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module monotonic_stack
  import digit_select_top_pkg::*;
#(
  parameter int max_cap = 12,
  parameter int SP_W    = $clog2(max_cap + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_en,
  input  digit_t          digit,
  input  logic [SP_W-1:0] floor_sp,
  input  logic            clear,
  input  logic [SP_W-1:0] rd_idx,
  output digit_t          rd_digit,
  output logic            full,
  output logic            empty
);

  digit_t          data [0:max_cap-1];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] j;
  logic [SP_W-1:0] new_sp;
  logic            do_push;

  // Lowest index holding a digit smaller than the incoming one. The stack is
  // non-increasing, so everything from j up to sp-1 is smaller too.
  always_comb begin
    j = sp;
    for (int i = max_cap - 1; i >= 0; i--) begin
      if ((SP_W'(i) < sp) && (data[i] < digit)) begin
        j = SP_W'(i);
      end
    end
  end

  // Never pop so deep that the remaining digits could not refill the stack
  assign new_sp  = (j > floor_sp) ? j : floor_sp;
  assign do_push = push_en && (new_sp < SP_W'(max_cap));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp   <= '0;
      data <= '{default: '0};
    end else if (clear) begin
      sp   <= '0;
      data <= '{default: '0};
    end else if (do_push) begin
      data[new_sp] <= digit;
      sp           <= new_sp + 1'b1;
    end
  end

  // Popped entries keep stale values, so mask anything at or above sp
  assign rd_digit = (rd_idx < sp) ? data[rd_idx] : '0;
  assign full     = (sp == SP_W'(max_cap));
  assign empty    = (sp == '0);

endmodule
`default_nettype wire

// File: rtl/digit_select_top.sv
`default_nettype none
// ============================================================================
//  Module      : digit_select_top
//  Description : Streaming largest-K-digit subsequence engine. Digits of one
//                line are folded into a monotonic stack; on newline the stack
//                is converted to binary and pulsed out for one cycle, after
//                which the block clears itself for the next line.
//  Ports       : clock, reset (async, active-low)
//                data_in_valid/data_in - one digit per cycle (value 0..9)
//                newline               - level, end of current line
//                full/empty            - stack occupancy
//                data_out_valid/data_out - one-cycle result per line
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_select_top
  import digit_select_top_pkg::*;
#(
  parameter int line_length = 100,
  parameter int max_cap     = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    data_in_valid,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    newline,
  output logic                    full,
  output logic                    empty,
  output logic                    data_out_valid,
  output logic [2*DATA_WIDTH-1:0] data_out
);

  localparam int SP_W  = $clog2(max_cap + 1);
  localparam int POS_W = $clog2(line_length + 1);
  localparam int ACC_W = 2 * DATA_WIDTH;

  state_t           state;
  state_t           state_next;
  logic [POS_W-1:0] pos;
  logic [SP_W-1:0]  idx;
  logic [SP_W-1:0]  floor_sp;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  digit_t           rd_digit;
  int               rem;
  logic             accept;
  logic             start_drain;
  logic             drain_en;
  logic             last_drain;
  logic             clear_line;
  logic             unused_hi;

  // Only the low nibble carries the digit
  assign unused_hi = ^data_in[DATA_WIDTH-1:4];

  // Minimum stack depth that must survive so the rest of the line can still
  // fill all max_cap slots
  always_comb begin
    rem      = line_length - int'(pos);
    floor_sp = '0;
    if (max_cap > rem) begin
      floor_sp = SP_W'(max_cap - rem);
    end
  end

  assign accept = (state == S_IDLE) && data_in_valid && !newline &&
                  (pos < POS_W'(line_length));

  monotonic_stack #(
    .max_cap (max_cap)
  ) stack (
    .clock    (clock),
    .reset    (reset),
    .push_en  (accept),
    .digit    (data_in[3:0]),
    .floor_sp (floor_sp),
    .clear    (clear_line),
    .rd_idx   (idx),
    .rd_digit (rd_digit),
    .full     (full),
    .empty    (empty)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (newline) state_next = S_DRAIN;
      S_DRAIN:   if (idx == SP_W'(max_cap - 1)) state_next = S_DONE;
      S_DONE:    state_next = S_WAIT_NL;
      S_WAIT_NL: if (!newline) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    start_drain = (state == S_IDLE) && newline;
    drain_en    = (state == S_DRAIN);
    last_drain  = drain_en && (idx == SP_W'(max_cap - 1));
    clear_line  = (state == S_WAIT_NL) && !newline;
  end

  assign acc_next = acc * ACC_W'(10) + ACC_W'(rd_digit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos            <= '0;
      idx            <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= last_drain;
      if (clear_line) begin
        pos <= '0;
      end else if (accept) begin
        pos <= pos + 1'b1;
      end
      if (start_drain) begin
        idx <= '0;
        acc <= '0;
      end else if (drain_en) begin
        idx <= idx + 1'b1;
        acc <= acc_next;
      end else if (clear_line) begin
        acc <= '0;
      end
      // data_out holds the last result until the next drain completes
      if (last_drain) begin
        data_out <= acc_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_select_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_select_top
//  Description : Scoreboard bench for digit_select_top. Instance a uses
//                15-digit lines, instance b uses 100-digit lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_select_top;

  localparam int MAXC = 12;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_data  = '0,   b_data  = '0;
  logic        a_nl    = 1'b0, b_nl    = 1'b0;
  logic        a_full, a_empty, a_ov, b_full, b_empty, b_ov;
  logic [63:0] a_out, b_out;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] sum_a = '0, sum_b = '0, ref_sum = '0;

  always #5 clock = ~clock;

  digit_select_top #(.line_length(15), .max_cap(MAXC)) dut_a (
    .clock(clock), .reset(rst_n), .data_in_valid(a_valid), .data_in(a_data),
    .newline(a_nl), .full(a_full), .empty(a_empty),
    .data_out_valid(a_ov), .data_out(a_out)
  );

  digit_select_top #(.line_length(100), .max_cap(MAXC)) dut_b (
    .clock(clock), .reset(rst_n), .data_in_valid(b_valid), .data_in(b_data),
    .newline(b_nl), .full(b_full), .empty(b_empty),
    .data_out_valid(b_ov), .data_out(b_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse is matched against the scoreboard queue
  always @(negedge clock) begin
    if (a_ov === 1'b1) begin
      if (exp_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_pulse: got data_out=%0d, expected no pulse", a_out);
      end else begin
        check("a_data_out", a_out, exp_a.pop_front());
      end
      sum_a += a_out;
    end
    if (b_ov === 1'b1) begin
      if (exp_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_pulse: got data_out=%0d, expected no pulse", b_out);
      end else begin
        check("b_data_out", b_out, exp_b.pop_front());
      end
      sum_b += b_out;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic nl);
    if (sel) begin b_valid = v; b_data = d; b_nl = nl; end
    else     begin a_valid = v; a_data = d; a_nl = nl; end
  endtask

  task automatic send_line(input bit sel, input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && (i % 2 == 1)) begin
        drive(sel, 1'b0, 32'd9, 1'b0);
        tick();
      end
      drive(sel, 1'b1, 32'(s[i] - 8'd48), 1'b0);
      tick();
    end
    drive(sel, 1'b0, 32'd0, 1'b0);
  endtask

  // Issue newline, push the expected result, and confirm it was consumed
  task automatic end_line(input bit sel, input logic [63:0] exp);
    int pending;
    if (sel) exp_b.push_back(exp); else exp_a.push_back(exp);
    drive(sel, 1'b0, 32'd0, 1'b1);
    repeat (MAXC + 3) tick();
    drive(sel, 1'b0, 32'd0, 1'b0);
    repeat (2) tick();
    pending = sel ? exp_b.size() : exp_a.size();
    tests++;
    if (pending != 0) begin
      fails++;
      $display("FAIL %s_pulse_missing: got %0d pending, expected 0", sel ? "b" : "a", pending);
      if (sel) exp_b.delete(); else exp_a.delete();
    end
  endtask

  // Reference: pick each digit as the largest in the window that still
  // leaves enough digits for the remaining slots
  function automatic logic [63:0] best_k(input string s, input int k);
    int          start;
    int          bi;
    logic [63:0] v;
    start = 0;
    v     = '0;
    for (int i = 0; i < k; i++) begin
      bi = start;
      for (int p = start; p <= s.len() - k + i; p++) begin
        if (s[p] > s[bi]) bi = p;
      end
      v     = v * 64'd10 + 64'(s[bi] - 8'd48);
      start = bi + 1;
    end
    return v;
  endfunction

  string       lines [4] = '{"987654321111111", "811111111111119",
                             "234234234234278", "818181911112111"};
  logic [63:0] vals  [4] = '{64'd987654321111, 64'd811111111119,
                             64'd434234234278, 64'd888911112111};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string       s;
    logic [63:0] e;

    repeat (3) @(posedge clock);
    #1;
    check("reset_a_empty", 64'(a_empty), 64'd1);
    check("reset_a_full",  64'(a_full),  64'd0);
    check("reset_a_valid", 64'(a_ov),    64'd0);
    check("reset_a_out",   a_out,        64'd0);
    check("reset_b_empty", 64'(b_empty), 64'd1);
    rst_n = 1'b1;
    tick();

    // First example split so full can be observed around the 12th digit
    send_line(0, lines[0].substr(0, 10), 1'b0);
    check("a_full_after_11", 64'(a_full), 64'd0);
    send_line(0, lines[0].substr(11, 11), 1'b0);
    check("a_full_after_12", 64'(a_full), 64'd1);
    send_line(0, lines[0].substr(12, 14), 1'b0);
    end_line(0, vals[0]);
    check("a_empty_after_clear", 64'(a_empty), 64'd1);

    for (int n = 1; n < 4; n++) begin
      send_line(0, lines[n], 1'b0);
      end_line(0, vals[n]);
    end
    check("a_sum_examples", sum_a, 64'd3121910778619);

    // Strictly increasing run forces pops to stop at the floor
    send_line(0, "123456789012345", 1'b0);
    check("a_full_monotonic", 64'(a_full), 64'd1);
    end_line(0, 64'd456789012345);

    // Same lines with idle gaps between digits
    for (int n = 0; n < 4; n++) begin
      send_line(0, lines[n], 1'b1);
      end_line(0, vals[n]);
    end

    // Reset in the middle of a 100-digit line
    s = "";
    for (int i = 0; i < 50; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    send_line(1, s, 1'b0);
    rst_n = 1'b0;
    tick();
    check("b_sp_after_reset", 64'(dut_b.stack.sp), 64'd0);
    check("b_empty_after_reset", 64'(b_empty), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a drain: no pulse may follow
    s = "";
    for (int i = 0; i < 100; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    send_line(1, s, 1'b0);
    drive(1, 1'b0, 32'd0, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    drive(1, 1'b0, 32'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (MAXC + 4) tick();
    check("b_sp_after_drain_reset", 64'(dut_b.stack.sp), 64'd0);

    // Random full lines against the reference, with a running sum
    sum_b = '0;
    for (int n = 0; n < 200; n++) begin
      s = "";
      for (int i = 0; i < 100; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
      e = best_k(s, MAXC);
      ref_sum += e;
      send_line(1, s, n[0]);
      end_line(1, e);
    end
    check("b_line_sum", sum_b, ref_sum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
